// File: rtl/mdr_alu_pkg.sv
// Shared constants for the MDR / bus encoder / ALU datapath block:
// ALU opcodes and the bus-source indices that the encoder produces.
package mdr_alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Bus-source indices above the general-purpose registers R0..R15
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHI    = 5'd18;
    localparam logic [4:0] SRC_ZLO    = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_CSIGN  = 5'd23;

endpackage

// File: rtl/mdr_alu_enc_divider.sv
// Combinational signed 32/32 divider. Quotient truncates toward zero and the
// remainder takes the dividend's sign; divide-by-zero and MIN/-1 are pinned.
module alu_divider
    import mdr_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);

    always_comb begin
        quot_o = '0;
        rem_o  = '0;
        if (b_i == '0) begin
            quot_o = '1;
            rem_o  = a_i;
        end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
            // The true quotient +2^31 is unrepresentable; it wraps to MIN
            quot_o = 32'h8000_0000;
            rem_o  = '0;
        end else begin
            quot_o = $signed(a_i) / $signed(b_i);
            rem_o  = $signed(a_i) % $signed(b_i);
        end
    end

endmodule

// File: rtl/mdr_alu_enc.sv
// Memory Data Register, 32-to-5 bus-source priority encoder and the
// combinational ALU feeding Z_HI/Z_LO.
module mdr_alu_enc
    import mdr_alu_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              MDR_enable,
    input  logic              Read,
    input  logic [DATA_W-1:0] MDatain,
    input  logic [DATA_W-1:0] BusMuxOut,
    output logic [DATA_W-1:0] MDR_out,
    input  logic [DATA_W-1:0] encoder_in,
    output logic [4:0]        encoder_out,
    input  logic              IncPC,
    input  logic [DATA_W-1:0] Y,
    input  logic [4:0]        opcode,
    output logic [DATA_W-1:0] C_out_HI,
    output logic [DATA_W-1:0] C_out_LO
);

    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] mdr_d;

    assign mdr_d = Read ? MDatain : BusMuxOut;

    always_ff @(posedge clk) begin
        if (!clr) begin
            mdr_q <= '0;
        end else if (MDR_enable) begin
            mdr_q <= mdr_d;
        end
    end

    assign MDR_out = mdr_q;

    // Ascending scan so the highest set bit is the last one written
    always_comb begin
        encoder_out = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (encoder_in[i]) begin
                encoder_out = i[4:0];
            end
        end
    end

    logic [4:0]        shamt;
    logic [63:0]       rot_r;
    logic [63:0]       rot_l;
    logic signed [63:0] prod;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;

    assign shamt = BusMuxOut[4:0];
    assign rot_r = {Y, Y} >> shamt;
    assign rot_l = {Y, Y} << shamt;
    assign prod  = $signed({{32{Y[31]}}, Y}) * $signed({{32{BusMuxOut[31]}}, BusMuxOut});

    alu_divider u_div (
        .a_i    (Y),
        .b_i    (BusMuxOut),
        .quot_o (div_q),
        .rem_o  (div_r)
    );

    always_comb begin
        C_out_HI = '0;
        C_out_LO = '0;
        if (IncPC) begin
            C_out_LO = BusMuxOut + 32'd1;
        end else begin
            case (opcode)
                OP_ADD:  C_out_LO = Y + BusMuxOut;
                OP_SUB:  C_out_LO = Y - BusMuxOut;
                OP_AND:  C_out_LO = Y & BusMuxOut;
                OP_OR:   C_out_LO = Y | BusMuxOut;
                OP_SHR:  C_out_LO = Y >> shamt;
                OP_SHRA: C_out_LO = $signed(Y) >>> shamt;
                OP_SHL:  C_out_LO = Y << shamt;
                OP_ROR:  C_out_LO = rot_r[31:0];
                OP_ROL:  C_out_LO = rot_l[63:32];
                OP_MUL: begin
                    C_out_HI = prod[63:32];
                    C_out_LO = prod[31:0];
                end
                OP_DIV: begin
                    C_out_HI = div_r;
                    C_out_LO = div_q;
                end
                OP_NEG:  C_out_LO = -BusMuxOut;
                OP_NOT:  C_out_LO = ~BusMuxOut;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_alu_enc.sv
// Directed bench for mdr_alu_enc: MDR load/hold/reset sequences plus
// table-driven encoder and ALU vectors with hand-computed results.
module tb_mdr_alu_enc;

    logic        clk = 1'b0;
    logic        clr;
    logic        MDR_enable;
    logic        Read;
    logic [31:0] MDatain;
    logic [31:0] BusMuxOut;
    logic [31:0] MDR_out;
    logic [31:0] encoder_in;
    logic [4:0]  encoder_out;
    logic        IncPC;
    logic [31:0] Y;
    logic [4:0]  opcode;
    logic [31:0] C_out_HI;
    logic [31:0] C_out_LO;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdr_alu_enc dut (
        .clk         (clk),
        .clr         (clr),
        .MDR_enable  (MDR_enable),
        .Read        (Read),
        .MDatain     (MDatain),
        .BusMuxOut   (BusMuxOut),
        .MDR_out     (MDR_out),
        .encoder_in  (encoder_in),
        .encoder_out (encoder_out),
        .IncPC       (IncPC),
        .Y           (Y),
        .opcode      (opcode),
        .C_out_HI    (C_out_HI),
        .C_out_LO    (C_out_LO)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    typedef struct {
        string       name;
        logic        inc;
        logic [4:0]  op;
        logic [31:0] y;
        logic [31:0] bus;
        logic [31:0] hi;
        logic [31:0] lo;
    } alu_vec_t;

    typedef struct {
        logic [31:0] in;
        logic [4:0]  out;
    } enc_vec_t;

    alu_vec_t av[25];
    enc_vec_t ev[6];

    initial begin
        av[0]  = '{"add",        1'b0, 5'b00011, 32'd7,          32'd5,          32'h0,          32'd12};
        av[1]  = '{"sub",        1'b0, 5'b00100, 32'd7,          32'd5,          32'h0,          32'd2};
        av[2]  = '{"and",        1'b0, 5'b00101, 32'd7,          32'd5,          32'h0,          32'd5};
        av[3]  = '{"or",         1'b0, 5'b00110, 32'd7,          32'd5,          32'h0,          32'd7};
        av[4]  = '{"add_wrap",   1'b0, 5'b00011, 32'hFFFFFFFF,   32'd1,          32'h0,          32'h0};
        av[5]  = '{"sub_wrap",   1'b0, 5'b00100, 32'd5,          32'd7,          32'h0,          32'hFFFFFFFE};
        av[6]  = '{"neg",        1'b0, 5'b10001, 32'd9,          32'd5,          32'h0,          32'hFFFFFFFB};
        av[7]  = '{"not",        1'b0, 5'b10010, 32'd9,          32'd0,          32'h0,          32'hFFFFFFFF};
        av[8]  = '{"shr",        1'b0, 5'b00111, 32'h80000001,   32'd4,          32'h0,          32'h08000000};
        av[9]  = '{"shra",       1'b0, 5'b01000, 32'h80000001,   32'd4,          32'h0,          32'hF8000000};
        av[10] = '{"shl",        1'b0, 5'b01001, 32'h80000001,   32'd4,          32'h0,          32'h00000010};
        av[11] = '{"ror",        1'b0, 5'b01010, 32'h80000001,   32'd4,          32'h0,          32'h18000000};
        av[12] = '{"rol",        1'b0, 5'b01011, 32'h80000001,   32'd4,          32'h0,          32'h00000018};
        av[13] = '{"ror_s0",     1'b0, 5'b01010, 32'h12345678,   32'h00000020,   32'h0,          32'h12345678};
        av[14] = '{"shr_amt_lo5",1'b0, 5'b00111, 32'hF0000000,   32'h00000024,   32'h0,          32'h0F000000};
        av[15] = '{"mul_neg",    1'b0, 5'b01111, 32'hFFFFFFFD,   32'd6,          32'hFFFFFFFF,   32'hFFFFFFEE};
        av[16] = '{"mul_big",    1'b0, 5'b01111, 32'h00010000,   32'h00010000,   32'h00000001,   32'h00000000};
        av[17] = '{"div_neg",    1'b0, 5'b10000, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD};
        av[18] = '{"div_negb",   1'b0, 5'b10000, 32'd7,          32'hFFFFFFFE,   32'h00000001,   32'hFFFFFFFD};
        av[19] = '{"div_zero",   1'b0, 5'b10000, 32'h00000123,   32'd0,          32'h00000123,   32'hFFFFFFFF};
        av[20] = '{"div_ovf",    1'b0, 5'b10000, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   32'h80000000};
        av[21] = '{"div_pos",    1'b0, 5'b10000, 32'd100,        32'd7,          32'd2,          32'd14};
        av[22] = '{"incpc",      1'b1, 5'b00101, 32'hAAAAAAAA,   32'h00000FFF,   32'h0,          32'h00001000};
        av[23] = '{"incpc_mul",  1'b1, 5'b01111, 32'hFFFFFFFD,   32'hFFFFFFFF,   32'h0,          32'h00000000};
        av[24] = '{"bad_op",     1'b0, 5'b11111, 32'h12345678,   32'h9ABCDEF0,   32'h0,          32'h0};

        ev[0] = '{32'h00200000, 5'd21};
        ev[1] = '{32'h00100008, 5'd20};
        ev[2] = '{32'h00000000, 5'd0};
        ev[3] = '{32'h80000000, 5'd31};
        ev[4] = '{32'hFFFFFFFF, 5'd31};
        ev[5] = '{32'h00000002, 5'd1};

        clr        = 1'b0;
        MDR_enable = 1'b0;
        Read       = 1'b0;
        MDatain    = 32'h0;
        BusMuxOut  = 32'h0;
        encoder_in = 32'h0;
        IncPC      = 1'b0;
        Y          = 32'h0;
        opcode     = 5'h0;

        // MDR sequences
        @(posedge clk); #1;
        check("mdr_reset", MDR_out, 32'h0);

        @(negedge clk);
        clr = 1'b1; Read = 1'b1; MDatain = 32'hDEADBEEF; BusMuxOut = 32'h11111111; MDR_enable = 1'b1;
        @(posedge clk); #1;
        check("mdr_load_mem", MDR_out, 32'hDEADBEEF);

        @(negedge clk);
        Read = 1'b0; BusMuxOut = 32'h12345678;
        @(posedge clk); #1;
        check("mdr_load_bus", MDR_out, 32'h12345678);

        @(negedge clk);
        MDR_enable = 1'b0; BusMuxOut = 32'hCAFEF00D; MDatain = 32'h0BADF00D;
        @(posedge clk); #1;
        check("mdr_hold", MDR_out, 32'h12345678);
        @(negedge clk);
        Read = 1'b1;
        @(posedge clk); #1;
        check("mdr_hold2", MDR_out, 32'h12345678);

        @(negedge clk);
        clr = 1'b0; MDR_enable = 1'b1;
        @(posedge clk); #1;
        check("mdr_clr_over_en", MDR_out, 32'h0);

        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        check("mdr_reload", MDR_out, 32'h0BADF00D);
        @(negedge clk);
        MDR_enable = 1'b0;

        // Encoder table
        for (int i = 0; i < 6; i++) begin
            encoder_in = ev[i].in;
            #1;
            check($sformatf("enc_%08h", ev[i].in), {27'h0, encoder_out}, {27'h0, ev[i].out});
        end

        // ALU table
        for (int i = 0; i < 25; i++) begin
            IncPC     = av[i].inc;
            opcode    = av[i].op;
            Y         = av[i].y;
            BusMuxOut = av[i].bus;
            #1;
            check({av[i].name, "_lo"}, C_out_LO, av[i].lo);
            check({av[i].name, "_hi"}, C_out_HI, av[i].hi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdr_alu_enc.md
# mdr_alu_enc

Datapath support block for the 32-bit RISC CPU. It holds the Memory Data Register (MDR) and the 32-to-5 bus-source priority encoder. It also holds the combinational ALU that produces the 64-bit result later latched into Z_HI/Z_LO. The block sits between the shared bus, the memory data input and the Y/Z registers.

## Interface
- No parameters; all widths fixed (32-bit data, 5-bit opcode/select).
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- MDR_enable  in  1  MDR load enable
- Read  in  1  MDR source select: 1 = MDatain, 0 = BusMuxOut
- MDatain  in  32  memory read data
- BusMuxOut  in  32  shared bus value; MDR bus source and ALU operand B
- MDR_out  out  32  MDR contents
- encoder_in  in  32  one-hot-ish bus-source request vector
- encoder_out  out  5  bus mux select
- IncPC  in  1  forces PC increment operation
- Y  in  32  ALU operand A (Y register)
- opcode  in  5  ALU operation
- C_out_HI  out  32  result high word
- C_out_LO  out  32  result low word

## Operation
- MDR, evaluated on each rising clk:
  - clr=0: MDR_out <= 0. Reset has priority over MDR_enable.
  - else MDR_enable=1: MDR_out <= (Read ? MDatain : BusMuxOut).
  - else hold.
- Encoder is combinational:
  - encoder_out = index of the highest set bit of encoder_in.
  - encoder_in = 0 gives encoder_out = 0.
  - Multiple bits set: the highest index wins.
- ALU is combinational. A = Y, B = BusMuxOut, shift amount s = B[4:0].
- Unless listed otherwise, C_out_HI = 0.
- IncPC=1 overrides opcode: C_out_LO = B + 1, modulo 2^32.
- Opcodes:
  - 00011 add: LO = A+B, carry discarded.
  - 00100 sub: LO = A−B, two's complement wrap.
  - 00101 and: LO = A&B.
  - 00110 or: LO = A|B.
  - 00111 shr: LO = A >> s, logical.
  - 01000 shra: LO = A >>> s, arithmetic (sign fill).
  - 01001 shl: LO = A << s.
  - 01010 ror: LO = A rotated right by s; s=0 gives A.
  - 01011 rol: LO = A rotated left by s.
  - 01111 mul: {HI,LO} = signed A × signed B, full 64-bit product.
  - 10000 div: signed A / B. LO = quotient truncated toward zero; HI = remainder with the sign of A.
    - B=0: LO = 32'hFFFFFFFF, HI = A.
    - A = 0x80000000 and B = −1: LO = 0x80000000, HI = 0.
  - 10001 neg: LO = −B.
  - 10010 not: LO = ~B.
  - Any other opcode: HI = LO = 0.

## Timing
- MDR: 1-cycle load latency. The new value is visible after the enabling edge.
- MDR reset value: 0. No other output has a reset value; encoder and ALU outputs follow their inputs combinationally.
- Encoder and ALU are purely combinational with zero latency. clk/clr do not affect them. Z_HI/Z_LO capture the ALU result externally on the Z_enable edge.
- Read/MDatain/BusMuxOut only need to be stable around the MDR_enable edge.
- A clr assertion mid-sequence clears MDR on that edge regardless of enable.
- The ALU result must settle within one clock period. Mul/div are single-cycle combinational; no handshake.

## Structure
- Shared package `mdr_alu_pkg`: opcode localparams (OP_ADD … OP_NOT) and encoder index constants (HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSIGN=23).
- Natural sub-module: `alu_divider`, a combinational signed 32/32 divider covering sign fix-up and the divide-by-zero/overflow cases.
- MDR and encoder are inline logic in the top level.

## Test plan
- MDR: clr=0 one edge → MDR_out=0. Then Read=1, MDatain=0xDEADBEEF, enable → 0xDEADBEEF. Then Read=0, bus=0x12345678, enable → 0x12345678. Enable=0 with bus changing → holds.
- Encoder: bit 21 only → 21. Bits {3,20} → 20. All zero → 0. Bit 31 → 31.
- ALU logic/arith: Y=7, bus=5:
  - add → LO=12.
  - sub → LO=2.
  - and → 5.
  - or → 7.
  - Y=0xFFFFFFFF + bus=1 → LO=0.
  - neg bus=5 → 0xFFFFFFFB; not bus=0 → 0xFFFFFFFF.
- Shifts with Y=0x80000001, bus=4:
  - shr → 0x08000000.
  - shra → 0xF8000000.
  - shl → 0x00000010.
  - ror → 0x18000000.
  - rol → 0x00000018.
- Mul/div:
  - mul Y=−3, bus=6 → HI=0xFFFFFFFF, LO=0xFFFFFFEE.
  - div Y=−7, bus=2 → LO=−3, HI=−1.
  - div bus=0 → LO=0xFFFFFFFF, HI=Y.
- IncPC=1, bus=0x00000FFF, opcode=and → LO=0x00001000, HI=0.
